// File: rtl/mmul_pkg.sv
// mmul_pkg: shared state encoding and default geometry for the matrix-multiply sequencer
package mmul_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, FLUSH, DRAIN} mmul_state_t;
  localparam int MMUL_N = 4;
  localparam int MMUL_DATA_WIDTH = 8;
  localparam int MMUL_ROW_W = 16;
  // zero beats needed to drain the skew and deskew pipelines of an n-wide array
  function automatic int flush_beats_default(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/mmul_beat_counter.sv
// mmul_beat_counter: saturating handshake counter with a target-reached flag
module mmul_beat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] target,
  output logic         hit
);
  logic [W-1:0] count;
  logic at_tgt;
  // hit includes the beat being accepted this cycle so the owner can act on it with zero latency
  assign at_tgt = count == target;
  assign hit = at_tgt || (inc && count == target - 1'b1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (inc && !at_tgt) count <= count + 1'b1;
  end
endmodule

// File: rtl/mmul_seq_ctrl.sv
// mmul_seq_ctrl: per-job weight load, activation stream and zero flush in front of the systolic array
// Optional watchdog with sticky timeout_err enabled by defining MMUL_SEQ_TIMEOUT_EN.
module mmul_seq_ctrl
  import mmul_pkg::*;
#(
  parameter int N = MMUL_N,
  parameter int DATA_WIDTH = MMUL_DATA_WIDTH,
  parameter int ROW_W = MMUL_ROW_W,
  parameter int FLUSH_BEATS = flush_beats_default(N)
`ifdef MMUL_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ROW_W-1:0]        cmd_rows,
  input  logic [N*DATA_WIDTH-1:0] host_tdata,
  input  logic                    host_tvalid,
  output logic                    host_tready,
  output logic [N*DATA_WIDTH-1:0] arr_tdata,
  output logic                    arr_tvalid,
  input  logic                    arr_tready,
  output logic                    load_weight,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  output logic                    busy,
  output logic                    done
`ifdef MMUL_SEQ_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);
  localparam int CW = ROW_W + 2;
  mmul_state_t state;
  logic [ROW_W-1:0] m_q;
  logic pass, cmd_fire, in_beat, out_beat, in_hit, out_hit, in_next;
  logic [CW-1:0] in_tgt, out_tgt;
  always_comb begin
    pass = state == LOAD_W || state == STREAM;
    cmd_ready = state == IDLE;
    busy = state != IDLE;
    load_weight = state == LOAD_W;
    arr_tdata = pass ? host_tdata : '0;
    arr_tvalid = pass ? host_tvalid : state == FLUSH;
    host_tready = pass && arr_tready;
    cmd_fire = cmd_valid && cmd_ready;
    in_beat = arr_tvalid && arr_tready;
    out_beat = busy && mon_tvalid && mon_tready;
    in_tgt = state == LOAD_W ? CW'(N) : state == STREAM ? CW'(m_q) : CW'(FLUSH_BEATS);
    out_tgt = CW'(N) + CW'(m_q) + CW'(FLUSH_BEATS);
    in_next = in_beat && in_hit;
    done = state == DRAIN && out_hit;
  end
  // one input counter is reused per phase; it is cleared on every phase change
  mmul_beat_counter #(.W(CW)) u_in_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cmd_fire || in_next),
    .inc    (in_beat),
    .target (in_tgt),
    .hit    (in_hit)
  );
  mmul_beat_counter #(.W(CW)) u_out_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cmd_fire),
    .inc    (out_beat),
    .target (out_tgt),
    .hit    (out_hit)
  );
`ifdef MMUL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic to_hit, to_fire;
  mmul_beat_counter #(.W(TW)) u_to_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (!busy || in_beat || out_beat),
    .inc    (busy && !in_beat && !out_beat),
    .target (TW'(TIMEOUT_CYC)),
    .hit    (to_hit)
  );
  // a job that completes in the same cycle the watchdog expires is reported as done
  assign to_fire = to_hit && !done;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      m_q <= '0;
`ifdef MMUL_SEQ_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_fire) begin
          m_q <= cmd_rows;
          state <= LOAD_W;
        end
        LOAD_W: if (in_next) state <= m_q == '0 ? FLUSH : STREAM;
        STREAM: if (in_next) state <= FLUSH;
        FLUSH: if (in_next) state <= DRAIN;
        DRAIN: if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef MMUL_SEQ_TIMEOUT_EN
      if (to_fire) begin
        state <= IDLE;
        timeout_err <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_mmul_seq_ctrl.sv
// tb_mmul_seq_ctrl: randomized scenarios checked against a beat-level model of one job
module tb_mmul_seq_ctrl;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int RW = 16;
  localparam int FB = 2 * N - 1;
  localparam int BW = N * DW;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [RW-1:0] cmd_rows = '0;
  logic [BW-1:0] host_tdata = '0;
  logic host_tvalid = 1'b0;
  logic host_tready;
  logic [BW-1:0] arr_tdata;
  logic arr_tvalid;
  logic arr_tready = 1'b0;
  logic load_weight;
  logic mon_tvalid = 1'b0;
  logic mon_tready = 1'b0;
  logic busy;
  logic done;
`ifdef MMUL_SEQ_TIMEOUT_EN
  logic timeout_err;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmul_seq_ctrl #(
    .N(N), .DATA_WIDTH(DW), .ROW_W(RW)
`ifdef MMUL_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows),
    .host_tdata(host_tdata), .host_tvalid(host_tvalid), .host_tready(host_tready),
    .arr_tdata(arr_tdata), .arr_tvalid(arr_tvalid), .arr_tready(arr_tready),
    .load_weight(load_weight), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .busy(busy), .done(done)
`ifdef MMUL_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  task automatic test_reset;
    host_tvalid = 1'b1;
    host_tdata = BW'($urandom);
    arr_tready = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (host_tready !== 1'b0) begin failures++; $display("FAIL rst_host_tready got=%b exp=0", host_tready); end
    checks++; if (arr_tvalid !== 1'b0) begin failures++; $display("FAIL rst_arr_tvalid got=%b exp=0", arr_tvalid); end
    checks++; if (load_weight !== 1'b0) begin failures++; $display("FAIL rst_load_weight got=%b exp=0", load_weight); end
    checks++; if (arr_tdata !== '0) begin failures++; $display("FAIL rst_arr_tdata got=%h exp=0", arr_tdata); end
    @(negedge clk);
    reset = 1'b0;
    host_tvalid = 1'b0;
    @(negedge clk);
  endtask

  // Runs one job: the array must see N weight beats, then M host beats, then FB zero beats,
  // and done must pulse once when every array input has produced an output.
  task automatic run_job(input int m, input bit bp, input bit hold, output int acc_cyc);
    logic [BW-1:0] hq[$];
    logic [BW:0] got[$];
    logic [BW:0] e;
    int idx, nin, outcnt, dones, accs, cyc, stall, out_at_done;
    bit gap_done, fin;
    idx = 0; nin = 0; outcnt = 0; dones = 0; accs = 0; cyc = 0; stall = 0;
    out_at_done = -1; gap_done = 0; fin = 0; acc_cyc = -1;
    for (int i = 0; i < N + m; i++) hq.push_back(BW'($urandom));
    cmd_valid = 1'b1;
    cmd_rows = RW'(m);
    while (!fin && cyc < 2000) begin
      host_tvalid = idx < hq.size() && stall == 0 && (!bp || $urandom_range(0, 3) != 0);
      host_tdata = idx < hq.size() ? hq[idx] : BW'($urandom);
      arr_tready = bp ? (cyc % 2 == 0) : 1'b1;
      mon_tvalid = outcnt < nin && (!bp || $urandom_range(0, 1) == 1);
      mon_tready = !bp || $urandom_range(0, 3) != 0;
      #1;
      if (busy) begin
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL cmd_ready_busy cyc=%0d got=%b exp=0", cyc, cmd_ready); end
        checks++; if (load_weight !== (nin < N)) begin failures++; $display("FAIL load_weight cyc=%0d got=%b exp=%b", cyc, load_weight, nin < N); end
      end
      if (cmd_valid && cmd_ready) begin
        accs++;
        if (acc_cyc < 0) acc_cyc = cyc;
      end
      if (host_tvalid && host_tready) idx++;
      if (arr_tvalid && arr_tready) begin
        got.push_back({load_weight, arr_tdata});
        nin++;
      end
      if (mon_tvalid && mon_tready && busy) outcnt++;
      if (done) begin
        dones++;
        out_at_done = outcnt;
      end
      if (stall > 0) stall--;
      if (bp && !gap_done && idx == N + 2) begin
        stall = 3;
        gap_done = 1;
      end
      @(negedge clk);
      if (accs > 0 && !hold) cmd_valid = 1'b0;
      if (dones > 0) fin = 1;
      cyc++;
    end
    checks++; if (!fin) begin failures++; $display("FAIL job_timeout m=%0d got=no_done exp=done", m); end
    checks++; if (accs !== 1) begin failures++; $display("FAIL cmd_accepts m=%0d got=%0d exp=1", m, accs); end
    checks++; if (dones !== 1) begin failures++; $display("FAIL done_pulses m=%0d got=%0d exp=1", m, dones); end
    checks++; if (out_at_done !== N + m + FB) begin failures++; $display("FAIL out_beats_at_done m=%0d got=%0d exp=%0d", m, out_at_done, N + m + FB); end
    checks++; if (idx !== N + m) begin failures++; $display("FAIL host_beats m=%0d got=%0d exp=%0d", m, idx, N + m); end
    checks++; if (got.size() !== N + m + FB) begin failures++; $display("FAIL arr_beats m=%0d got=%0d exp=%0d", m, got.size(), N + m + FB); end
    for (int i = 0; i < got.size() && i < N + m + FB; i++) begin
      e = i < N ? {1'b1, hq[i]} : i < N + m ? {1'b0, hq[i]} : '0;
      checks++; if (got[i] !== e) begin failures++; $display("FAIL arr_beat[%0d] m=%0d got=%h exp=%h", i, m, got[i], e); end
    end
    host_tvalid = 1'b0;
    mon_tvalid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_done_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL post_done_done got=%b exp=0", done); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL post_done_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_basic;
    int a;
    run_job(3, 0, 0, a);
    checks++; if (a !== 0) begin failures++; $display("FAIL basic_accept_cyc got=%0d exp=0", a); end
  endtask

  task automatic test_m_zero;
    int a;
    run_job(0, 0, 0, a);
  endtask

  task automatic test_backpressure;
    int a;
    run_job(6, 1, 0, a);
    run_job(int'($urandom_range(3, 9)), 1, 0, a);
  endtask

  task automatic test_back_to_back;
    int a;
    run_job(3, 0, 1, a);
    run_job(2, 0, 0, a);
    checks++; if (a !== 0) begin failures++; $display("FAIL b2b_accept_cyc got=%0d exp=0", a); end
  endtask

  task automatic test_reset_mid_job;
    int nin, cyc, dones, a;
    bit acc;
    nin = 0; cyc = 0; dones = 0; acc = 0;
    cmd_valid = 1'b1;
    cmd_rows = RW'(5);
    while (nin < N + 2 && cyc < 100) begin
      host_tvalid = 1'b1;
      host_tdata = BW'($urandom);
      arr_tready = 1'b1;
      mon_tvalid = 1'b0;
      #1;
      if (cmd_valid && cmd_ready) acc = 1;
      if (arr_tvalid && arr_tready) nin++;
      if (done) dones++;
      @(negedge clk);
      if (acc) cmd_valid = 1'b0;
      cyc++;
    end
    checks++; if (nin !== N + 2) begin failures++; $display("FAIL rstmid_reach got=%0d exp=%0d", nin, N + 2); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (arr_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_arr_tvalid got=%b exp=0", arr_tvalid); end
    checks++; if (arr_tdata !== '0) begin failures++; $display("FAIL rstmid_arr_tdata got=%h exp=0", arr_tdata); end
    checks++; if (host_tready !== 1'b0) begin failures++; $display("FAIL rstmid_host_tready got=%b exp=0", host_tready); end
    checks++; if (load_weight !== 1'b0) begin failures++; $display("FAIL rstmid_load_weight got=%b exp=0", load_weight); end
    checks++; if (done !== 1'b0 || dones !== 0) begin failures++; $display("FAIL rstmid_done got=%b/%0d exp=0/0", done, dones); end
    @(negedge clk);
    reset = 1'b0;
    host_tvalid = 1'b0;
    @(negedge clk);
    run_job(2, 0, 0, a);
  endtask

`ifdef MMUL_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int idle, cyc, dones;
    bit acc, seen;
    idle = 0; cyc = 0; dones = 0; acc = 0; seen = 0;
    cmd_valid = 1'b1;
    cmd_rows = RW'(1);
    while (!seen && cyc < 200) begin
      host_tvalid = 1'b1;
      host_tdata = BW'($urandom);
      arr_tready = 1'b1;
      mon_tvalid = 1'b0;
      mon_tready = 1'b1;
      #1;
      if (timeout_err === 1'b1) seen = 1;
      else begin
        if (cmd_valid && cmd_ready) acc = 1;
        if (busy && !(arr_tvalid && arr_tready)) idle++;
        if (done) dones++;
        @(negedge clk);
        if (acc) cmd_valid = 1'b0;
        cyc++;
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL tmo_set got=0 exp=1"); end
    checks++; if (idle !== 16) begin failures++; $display("FAIL tmo_idle_cycles got=%0d exp=16", idle); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%b exp=0", busy); end
    checks++; if (dones !== 0) begin failures++; $display("FAIL tmo_done got=%0d exp=0", dones); end
    host_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", timeout_err); end
    reset = 1'b1;
    #1;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_reset got=%b exp=0", timeout_err); end
    @(negedge clk);
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_m_zero;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_job;
`ifdef MMUL_SEQ_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmul_seq_ctrl.md
Name: mmul_seq_ctrl

Overview:
- Sequencer in front of the systolic-array top (`top`).
- Per job it does three things, in order:
  - loads an N-beat weight tile from the host AXI-Stream with load_weight=1;
  - streams M activation beats;
  - injects zero flush beats so the skew and deskew pipelines drain.
- It drives the array's slave AXI-Stream and load_weight pin.
- It watches the array's master AXI-Stream handshake to decide job completion.
- One job at a time, started by a command handshake.

Parameters:
- N, 4, array dimension (beats per weight tile, lanes per beat).
- DATA_WIDTH, 8, lane width.
- ROW_W, 16, width of the activation row count.
- FLUSH_BEATS, 2*N-1, zero beats injected after activations (7 at N=4).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  high only in IDLE.
- cmd_rows  in  ROW_W  activation beat count M, sampled on the cmd handshake.
- host_tdata  in  N*DATA_WIDTH  weight then activation beats.
- host_tvalid  in  1  host data valid.
- host_tready  out  1  host data ready.
- arr_tdata  out  N*DATA_WIDTH  to array s_axis_tdata.
- arr_tvalid  out  1  to array s_axis_tvalid.
- arr_tready  in  1  from array s_axis_tready.
- load_weight  out  1  to array load_weight.
- mon_tvalid  in  1  array m_axis_tvalid (monitor only).
- mon_tready  in  1  array m_axis_tready (monitor only).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset (async, active-high): state=IDLE, all counters 0. Outputs reset to:
  - cmd_ready=1;
  - host_tready=0, arr_tvalid=0, load_weight=0, busy=0, done=0;
  - arr_tdata=0.
- Datapath is combinational pass-through in LOAD_W and STREAM:
  - arr_tdata=host_tdata, arr_tvalid=host_tvalid, host_tready=arr_tready;
  - zero added latency.
- An input beat counts only when arr_tvalid && arr_tready.
- An output beat counts only when mon_tvalid && mon_tready.
- IDLE:
  - cmd_valid && cmd_ready latches M=cmd_rows, clears counters, goes to LOAD_W.
  - M=0 is legal: STREAM is skipped (LOAD_W -> FLUSH).
- LOAD_W:
  - load_weight=1 combinationally for the whole state.
  - Counts N input beats; on the Nth accepted beat goes to STREAM (or FLUSH if M=0).
  - load_weight drops in the cycle after the last weight beat.
- STREAM:
  - load_weight=0; counts M input beats.
  - On the Mth accepted beat goes to FLUSH.
- FLUSH:
  - host_tready=0, so the host is stalled.
  - arr_tdata=0, arr_tvalid=1.
  - Counts FLUSH_BEATS accepted beats, then goes to DRAIN.
- DRAIN:
  - arr_tvalid=0.
  - Waits until the output-beat count equals N+M+FLUSH_BEATS, because each array input beat produces one output beat.
  - Then pulses done=1 for one cycle and returns to IDLE.
  - If the count is already reached on DRAIN entry, done fires in the first DRAIN cycle.
- Output-beat counter runs in every non-IDLE state.
  - It is ROW_W+2 bits wide; overflow cannot occur for legal M.
- Counters saturate at their target; no wrap.
- cmd_valid while busy is ignored (cmd_ready=0); the command is not queued.
- host_tvalid deasserting mid-LOAD_W or mid-STREAM:
  - simply stalls the job;
  - the counters hold, the state holds, and load_weight stays asserted in LOAD_W.
- Reset mid-job:
  - immediate return to IDLE with the reset values above;
  - no done pulse;
  - the partially loaded array state is the host's problem.
- A done pulse and a new cmd handshake cannot coincide: cmd_ready rises the cycle after done.

Optional Feature:
- Macro: MMUL_SEQ_TIMEOUT_EN.
- Defined:
  - adds parameter TIMEOUT_CYC (default 1024) and output port timeout_err (1 bit, reset 0, sticky until reset);
  - a counter resets on every counted input or output beat;
  - reaching TIMEOUT_CYC in any non-IDLE state sets timeout_err and forces IDLE with no done pulse.
- Undefined: no port, no counter; a stalled job waits forever.

Decomposition:
- Package mmul_pkg holds:
  - state enum IDLE / LOAD_W / STREAM / FLUSH / DRAIN;
  - default N, DATA_WIDTH, ROW_W;
  - a function returning the default FLUSH_BEATS (2*N-1).
- One natural sub-module, mmul_beat_counter: a parameterised-width counter with clear, increment-on-handshake and a target-reached flag.
  - Instantiated for input beats, output beats and (optionally) timeout.

Test Plan:
1. Basic job, N=4, M=3, host always valid, arr_tready=1, mon always handshaking:
   - load_weight high for exactly 4 accepted beats;
   - then 3 pass-through beats, then 7 zero beats;
   - done pulses once, after 14 output beats.
2. M=0 job: LOAD_W goes directly to FLUSH; done after 4+0+7=11 output beats.
3. Backpressure: arr_tready toggles 1,0,1,0 and host_tvalid drops for 3 cycles mid-STREAM.
   - Beat counts unchanged; the host sees every beat exactly once; tdata is passed through unaltered.
4. cmd_valid held high throughout job 1:
   - second job accepted only the cycle after done;
   - cmd_ready is 0 during busy.
5. Reset asserted asynchronously in STREAM after 2 beats:
   - outputs return to reset values without waiting for a clock edge;
   - no done pulse;
   - a subsequent job with M=2 completes normally.
6. With MMUL_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16:
   - mon_tvalid is held 0 in DRAIN;
   - timeout_err sets at the 16th idle cycle, state becomes IDLE, and done never pulses.
